alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Execute-to-writeback stage directly downstream of the 16-bit ALU.
- Each cycle it accepts one ALU result with its Z/R outputs, updates the architectural zero/carry flags and resolves conditional branches.
- Results are held in a 2-entry skid buffer and presented to the register-file writeback port over a valid/ready handshake.

Parameters:
- DATA_W, 16, ALU result and PC width.
- RD_W, 3, destination register index width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all buffered and incoming ops.
- in_valid  in  1  ALU op presented.
- in_ready  out  1  stage can accept.
- in_oper  in  4  ALU opcode.
- in_alu_c  in  DATA_W  ALU result C.
- in_alu_z  in  1  ALU zero output Z.
- in_alu_r  in  1  ALU borrow output R.
- in_rd  in  RD_W  destination register.
- in_pc  in  DATA_W  PC of op.
- in_imm  in  DATA_W  branch offset.
- out_valid  out  1  writeback entry available.
- out_ready  in  1  writeback consumer accepts.
- out_result  out  DATA_W  head result.
- out_rd  out  RD_W  head destination.
- out_wr_en  out  1  head writes the register file.
- flag_z  out  1  architectural zero flag.
- flag_c  out  1  architectural carry/borrow flag.
- br_taken  out  1  one-cycle redirect pulse.
- br_target  out  DATA_W  redirect PC.

Behaviour:
- Reset: buffer EMPTY, out_valid=0, out_result=0, out_rd=0, out_wr_en=0, flag_z=0, flag_c=0, br_taken=0, br_target=0, in_ready=1. Reset mid-operation drops all entries.
- Accept: in_valid && in_ready && !flush.
- Release: out_valid && out_ready.
- in_ready is registered: it is 1 unless the buffer is FULL.
- Occupancy FSM: EMPTY, ONE, FULL.
  - EMPTY -> ONE on accept.
  - ONE -> FULL on accept without release.
  - ONE -> EMPTY on release without accept.
  - ONE -> ONE on simultaneous accept and release.
  - FULL -> ONE on release. No accept is possible in FULL.
- Ordering: FIFO. The head is exposed on the out_* ports combinationally from the head register; out_* stay stable while out_valid && !out_ready.
- Flush: next state EMPTY. The op presented in the flush cycle is discarded, flags are not updated and br_taken is 0. Flush outranks accept and release.
- Opcode handling on accept:
  - 1100 ADD, 1101 ADI: enqueue, wr_en=1, flag_z<=in_alu_z, flag_c unchanged.
  - 0010 NAND: enqueue, wr_en=1, flag_z<=in_alu_z.
  - 1000 BEQ: taken if in_alu_z.
  - 1001 BLT: taken if in_alu_r.
  - 1010 BLE: taken if in_alu_z|in_alu_r.
  - Branches: flag_z<=in_alu_z, flag_c<=in_alu_r; enqueue with wr_en=0 to preserve order.
  - Other opcodes: enqueue with wr_en=0, flags unchanged.
- Branch redirect: registered, latency 1. br_taken=1 for exactly one cycle after accepting a taken branch. br_target=in_pc+in_imm, modulo 2^DATA_W (wrap, no overflow flag). br_target holds its last value when br_taken=0.
- Flags update one cycle after accept. They are never updated by flushed or refused ops.

Optional Feature:
- Macro WB_STALL_CNT_EN.
- Defined: extra output stall_cnt[15:0]. It increments each cycle out_valid && !out_ready, saturates at 0xFFFF and resets to 0 on rst. Flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: opcode constants (OP_ADD=1100, OP_ADI=1101, OP_BEQ=1000, OP_BLT=1001, OP_BLE=1010, OP_NAND=0010), occupancy state encoding, entry record (result, rd, wr_en).
- Sub-module wb_skid_buf: 2-entry FIFO with occupancy FSM and valid/ready, no opcode knowledge.
- Top level owns flags, branch resolution, flush gating.

Test Plan:
- Reset then ADD accept (in_alu_c=0x1234, rd=3, z=0), out_ready=1 -> next cycle out_valid=1, out_result=0x1234, out_rd=3, out_wr_en=1, flag_z=0.
- out_ready=0, three back-to-back ADDs 0x0001/0x0002/0x0003 -> in_ready=0 after second; third held off; release order 0x0001, 0x0002, then 0x0003 after re-accept; nothing lost or duplicated.
- BLT with in_alu_r=1, in_pc=0xFFF0, in_imm=0x0020 -> br_taken=1 for one cycle, br_target=0x0010 (wrap), flag_c=1, entry out_wr_en=0.
- BEQ with in_alu_z=0 -> br_taken stays 0; flag_z=0.
- Buffer FULL, flush=1 with in_valid=1 (NAND, z=1) -> next cycle out_valid=0, in_ready=1, flag_z unchanged.
- WB_STALL_CNT_EN defined: 5 cycles out_valid=1, out_ready=0 -> stall_cnt=5; counter preloaded 0xFFFF stays 0xFFFF.

Source files
------------

// File: rtl/alu_wb_stage_pkg.sv
// Shared definitions for the ALU writeback stage: opcodes, skid-buffer occupancy, entry record.
package alu_wb_stage_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_RD_W   = 3;

  localparam logic [3:0] OP_ADD  = 4'b1100;
  localparam logic [3:0] OP_ADI  = 4'b1101;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BLT  = 4'b1001;
  localparam logic [3:0] OP_BLE  = 4'b1010;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [WB_DATA_W-1:0] result;
    logic [WB_RD_W-1:0]   rd;
    logic                 wr_en;
  } wb_entry_t;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BLE);
  endfunction

endpackage

// File: rtl/alu_wb_stage_wb_skid_buf.sv
// Two-entry FIFO skid buffer with EMPTY/ONE/FULL occupancy FSM; head is exposed directly.
module wb_skid_buf
  import alu_wb_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t push_data,
  output logic      in_ready,
  output logic      out_valid,
  input  logic      out_ready,
  output wb_entry_t out_data
);

  occ_e      state_q, state_d;
  wb_entry_t head_q, head_d;
  wb_entry_t tail_q, tail_d;
  logic      in_ready_q, in_ready_d;
  logic      pop;

  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = head_q;
  assign in_ready  = in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (push) begin
          head_d  = push_data;
          state_d = OCC_ONE;
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_d = push_data;
          end else if (push) begin
            tail_d  = push_data;
            state_d = OCC_FULL;
          end else if (pop) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: if (pop) begin
          head_d  = tail_q;
          state_d = OCC_ONE;
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
    // Registered ready: looks at where occupancy is heading, not where it is.
    in_ready_d = (state_d != OCC_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OCC_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: flags, branch redirect, flush gating around a skid buffer.
// Optional WB_STALL_CNT_EN adds a saturating writeback stall counter output.
module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int RD_W   = WB_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_oper,
  input  logic [DATA_W-1:0] in_alu_c,
  input  logic              in_alu_z,
  input  logic              in_alu_r,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_en,
  output logic              flag_z,
  output logic              flag_c,
  output logic              br_taken,
`ifdef WB_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [DATA_W-1:0] br_target
);

  logic              accept, taken;
  wb_entry_t         in_entry, head;
  logic              flag_z_q, flag_z_d, flag_c_q, flag_c_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_target_q, br_target_d;

  assign accept = in_valid && in_ready && !flush;

  always_comb begin
    taken = 1'b0;
    case (in_oper)
      OP_BEQ:  taken = in_alu_z;
      OP_BLT:  taken = in_alu_r;
      OP_BLE:  taken = in_alu_z | in_alu_r;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    in_entry.result = in_alu_c;
    in_entry.rd     = in_rd;
    in_entry.wr_en  = (in_oper == OP_ADD) || (in_oper == OP_ADI) || (in_oper == OP_NAND);
  end

  always_comb begin
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
    if (accept) begin
      if (in_entry.wr_en) flag_z_d = in_alu_z;
      if (is_branch(in_oper)) begin
        flag_z_d = in_alu_z;
        flag_c_d = in_alu_r;
        if (taken) begin
          br_taken_d  = 1'b1;
          br_target_d = in_pc + in_imm;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  wb_skid_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (accept),
    .push_data (in_entry),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_result = head.result;
  assign out_rd     = head.rd;
  assign out_wr_en  = head.wr_en;
  assign flag_z     = flag_z_q;
  assign flag_c     = flag_c_q;
  assign br_taken   = br_taken_q;
  assign br_target  = br_target_q;

`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: directed scenarios followed by random traffic.
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [3:0]  in_oper;
  logic [15:0] in_alu_c, in_pc, in_imm;
  logic        in_alu_z, in_alu_r;
  logic [2:0]  in_rd;
  logic        out_valid, out_ready, out_wr_en;
  logic [15:0] out_result, br_target;
  logic [2:0]  out_rd;
  logic        flag_z, flag_c, br_taken;
`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int unsigned m_cnt;
`endif

  always #5 clk = ~clk;

  alu_wb_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_oper(in_oper), .in_alu_c(in_alu_c), .in_alu_z(in_alu_z), .in_alu_r(in_alu_r),
    .in_rd(in_rd), .in_pc(in_pc), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .flag_z(flag_z), .flag_c(flag_c), .br_taken(br_taken),
`ifdef WB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .br_target(br_target)
  );

  typedef struct {
    logic [15:0] res;
    logic [2:0]  rd;
    logic        we;
  } ent_t;

  ent_t        sb[$];
  logic        m_z, m_c, m_bt;
  logic [15:0] m_tgt;
  bit          m_live = 0, m_rst_chk = 0;
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference rules: ops that write the register file, and the branch condition.
  function automatic bit writes_rf(input logic [3:0] op);
    return op == 4'hC || op == 4'hD || op == 4'h2;
  endfunction

  function automatic bit is_br(input logic [3:0] op);
    return op == 4'h8 || op == 4'h9 || op == 4'hA;
  endfunction

  function automatic bit br_cond(input logic [3:0] op, input logic z, input logic r);
    if (op == 4'h8) return z;
    if (op == 4'h9) return r;
    if (op == 4'hA) return z | r;
    return 0;
  endfunction

  // Monitor on the falling edge: compare what the DUT shows, then advance the model
  // to what the coming rising edge should produce.
  always @(negedge clk) begin
    bit   room, acc;
    ent_t e;
    room = sb.size() < 2;
    if (m_live) begin
      chk("in_ready", 32'(in_ready), 32'(room));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("out_result", 32'(out_result), 32'(sb[0].res));
        chk("out_rd", 32'(out_rd), 32'(sb[0].rd));
        chk("out_wr_en", 32'(out_wr_en), 32'(sb[0].we));
      end else if (m_rst_chk) begin
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);
        chk("rst_wr_en", 32'(out_wr_en), 32'd0);
      end
      chk("flag_z", 32'(flag_z), 32'(m_z));
      chk("flag_c", 32'(flag_c), 32'(m_c));
      chk("br_taken", 32'(br_taken), 32'(m_bt));
      chk("br_target", 32'(br_target), 32'(m_tgt));
`ifdef WB_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      if (sb.size() != 0 && !out_ready && m_cnt < 32'hFFFF) m_cnt++;
`endif
      if (sb.size() != 0 && out_ready) void'(sb.pop_front());
    end
    if (rst) begin
      sb.delete();
      {m_z, m_c, m_bt, m_tgt} = '0;
      m_live = 1;
      m_rst_chk = 1;
`ifdef WB_STALL_CNT_EN
      m_cnt = 0;
`endif
    end else begin
      m_rst_chk = 0;
      m_bt = 0;
      acc = in_valid && room && !flush;
      if (flush) sb.delete();
      else if (acc) begin
        e.res = in_alu_c; e.rd = in_rd; e.we = writes_rf(in_oper);
        sb.push_back(e);
        if (writes_rf(in_oper)) m_z = in_alu_z;
        if (is_br(in_oper)) begin
          m_z = in_alu_z;
          m_c = in_alu_r;
          if (br_cond(in_oper, in_alu_z, in_alu_r)) begin
            m_bt = 1;
            m_tgt = in_pc + in_imm;
          end
        end
      end
    end
  end

  task automatic set_op(input logic [3:0] op, input logic [15:0] c, input logic z,
                        input logic r, input logic [2:0] rd, input logic [15:0] pc,
                        input logic [15:0] imm);
    in_oper = op; in_alu_c = c; in_alu_z = z; in_alu_r = r;
    in_rd = rd; in_pc = pc; in_imm = imm;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one op until it is accepted, bounded by a cycle budget.
  task automatic send(input logic [3:0] op, input logic [15:0] c, input logic z,
                      input logic r, input logic [2:0] rd, input logic [15:0] pc,
                      input logic [15:0] imm);
    bit taken_in;
    int budget;
    set_op(op, c, z, r, rd, pc, imm);
    in_valid = 1;
    budget = 50;
    do begin
      taken_in = in_ready;
      tick();
      budget--;
    end while (!taken_in && budget > 0);
    if (!taken_in) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 0;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    set_op(4'h0, 16'h0, 0, 0, 3'd0, 16'h0, 16'h0);
    tick(); tick();
    rst = 0;
    tick();

    out_ready = 1;
    send(4'hC, 16'h1234, 0, 0, 3'd3, 16'h0, 16'h0);
    tick(); tick();

    out_ready = 0;
    in_valid = 1;
    set_op(4'hC, 16'h0001, 0, 0, 3'd1, 16'h0, 16'h0); tick();
    set_op(4'hC, 16'h0002, 1, 0, 3'd2, 16'h0, 16'h0); tick();
    set_op(4'hC, 16'h0003, 0, 0, 3'd4, 16'h0, 16'h0); tick();
    in_valid = 0;
    tick();
    out_ready = 1;
    send(4'hC, 16'h0003, 0, 0, 3'd4, 16'h0, 16'h0);
    tick(); tick(); tick();

    send(4'h9, 16'hAAAA, 0, 1, 3'd5, 16'hFFF0, 16'h0020);
    tick(); tick();
    send(4'h8, 16'h5555, 0, 0, 3'd6, 16'h1000, 16'h0004);
    tick(); tick();

    out_ready = 0;
    send(4'hD, 16'h00AA, 0, 0, 3'd1, 16'h0, 16'h0);
    send(4'hD, 16'h00BB, 0, 0, 3'd2, 16'h0, 16'h0);
    tick();
    flush = 1; in_valid = 1;
    set_op(4'h2, 16'hFFFF, 1, 0, 3'd7, 16'h0, 16'h0);
    tick();
    flush = 0; in_valid = 0;
    tick(); tick();

    out_ready = 0; in_valid = 1;
    set_op(4'hC, 16'h0042, 0, 0, 3'd3, 16'h0, 16'h0);
    repeat (6) tick();
    in_valid = 0;
    out_ready = 1;
    tick(); tick(); tick();

    for (int i = 0; i < 3000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 31) == 0;
      rst       = (i == 1500);
      if ($urandom_range(0, 1) != 0) begin
        case ($urandom_range(0, 5))
          0: in_oper = 4'hC; 1: in_oper = 4'hD; 2: in_oper = 4'h2;
          3: in_oper = 4'h8; 4: in_oper = 4'h9; default: in_oper = 4'hA;
        endcase
      end else in_oper = 4'($urandom_range(0, 15));
      in_alu_c = 16'($urandom);
      in_alu_z = 1'($urandom);
      in_alu_r = 1'($urandom);
      in_rd    = 3'($urandom);
      in_pc    = 16'($urandom);
      in_imm   = 16'($urandom);
      tick();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
